// File: rtl/port_slice_pkg.sv
// Shared constants and helpers for the port slice bank.
//   NCH_DEF    default number of channels
//   WIDTH_DEF  default data bits per channel
//   DEPTH_DEF  default entries per channel buffer
//   occ_width  bits needed to hold an occupancy count of 0..depth
package port_slice_pkg;

  localparam int NCH_DEF   = 3;
  localparam int WIDTH_DEF = 1;
  localparam int DEPTH_DEF = 2;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/slice_fifo.sv
// One channel of the port slice bank: a DEPTH-entry FIFO with registered
// handshake outputs and a registered head-of-queue data word.
//   clk, rst    clock and asynchronous active-high reset
//   flush       synchronous clear; same-cycle push/pop are ignored
//   in_valid    write request      in_ready   write acceptance (from a flop)
//   in_data     write data
//   out_valid   head entry present out_ready  read acceptance
//   out_data    oldest entry (registered)
//   occ         number of entries held
module slice_fifo
  import port_slice_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  occ
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [OCC_W-1:0] occ_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  assign push       = in_valid && in_ready && !flush;
  assign pop        = out_valid && out_ready && !flush;
  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  always_comb begin
    occ_nxt = occ;
    if (flush) begin
      occ_nxt = '0;
    end else if (push && !pop) begin
      occ_nxt = occ + OCC_ONE;
    end else if (pop && !push) begin
      occ_nxt = occ - OCC_ONE;
    end
  end

  // Control state; ready/valid are precomputed from the next occupancy so
  // both come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      in_ready  <= (occ_nxt != OCC_FULL);
      out_valid <= (occ_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Head register. The incoming word becomes the head when the queue is
  // empty, or when the only entry is being popped in the same cycle;
  // otherwise a pop promotes the next stored entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (push && ((occ == '0) || (pop && (occ == OCC_ONE)))) begin
      out_data <= in_data;
    end else if (pop && (occ != OCC_ONE)) begin
      out_data <= mem[rd_ptr_inc];
    end
  end

endmodule

// File: rtl/port_slice_bank.sv
// Bank of NCH independent channel FIFOs sharing clock, reset and flush.
//   clk, rst, flush  shared clock, async active-high reset, sync clear
//   in_valid/in_ready/in_data     per-channel write side, channel k data
//                                 at [k*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data  per-channel read side, same packing
//   occ              per-channel occupancy, packed by occ_width(DEPTH)
//   busy             any channel holds data
module port_slice_bank
  import port_slice_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NCH-1:0]                    in_valid,
  output logic [NCH-1:0]                    in_ready,
  input  logic [NCH*WIDTH-1:0]              in_data,
  output logic [NCH-1:0]                    out_valid,
  input  logic [NCH-1:0]                    out_ready,
  output logic [NCH*WIDTH-1:0]              out_data,
  output logic [NCH*occ_width(DEPTH)-1:0]   occ,
  output logic                              busy
);

  localparam int OCC_W = occ_width(DEPTH);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    slice_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k*WIDTH +: WIDTH]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .occ       (occ[k*OCC_W +: OCC_W])
    );
  end

  assign busy = |out_valid;

endmodule

// File: tb/tb_port_slice_bank.sv
module tb_port_slice_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 3 channels, 8-bit data, depth 2
  logic        flush_a;
  logic [2:0]  iv_a, ir_a, ov_a, or_a;
  logic [23:0] id_a, od_a;
  logic [5:0]  occ_a;
  logic        busy_a;

  // Instance B: 3 channels, 1-bit data, depth 4
  logic        flush_b;
  logic [2:0]  iv_b, ir_b, ov_b, or_b;
  logic [2:0]  id_b, od_b;
  logic [8:0]  occ_b;
  logic        busy_b;

  port_slice_bank #(.NCH(3), .WIDTH(8), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .occ(occ_a), .busy(busy_a)
  );

  port_slice_bank #(.NCH(3), .WIDTH(1), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .occ(occ_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model for instance A: one plain list per channel.
  logic [7:0] qa [3][$];

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic [7:0] d;
    int         e_occ;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_head;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a();
    logic any;
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("a.occ[%0d]", k), occ_a[k*2 +: 2], qa[k].size());
      chk($sformatf("a.in_ready[%0d]", k), ir_a[k], qa[k].size() < 2);
      chk($sformatf("a.out_valid[%0d]", k), ov_a[k], qa[k].size() != 0);
      if (qa[k].size() != 0) begin
        any = 1'b1;
        chk($sformatf("a.head[%0d]", k), od_a[k*8 +: 8], qa[k][0]);
      end
    end
    chk("a.busy", busy_a, any);
  endtask

  task automatic step_a(input logic [2:0] iv, input logic [2:0] ordy,
                        input logic fl, input logic [23:0] d);
    bit pu [3];
    bit po [3];
    iv_a = iv; or_a = ordy; flush_a = fl; id_a = d;
    for (int k = 0; k < 3; k++) begin
      pu[k] = iv[k] && (qa[k].size() < 2) && !fl;
      po[k] = ordy[k] && (qa[k].size() != 0) && !fl;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      if (fl) qa[k].delete();
      else begin
        if (po[k]) void'(qa[k].pop_front());
        if (pu[k]) qa[k].push_back(d[k*8 +: 8]);
      end
    end
    check_a();
  endtask

  task automatic step_b(input logic [2:0] iv, input logic [2:0] ordy, input logic [2:0] d);
    iv_b = iv; or_b = ordy; id_b = d; flush_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".a.out_valid"}, ov_a, 3'b000);
    chk({tag, ".a.occ"}, occ_a, 6'd0);
    chk({tag, ".a.in_ready"}, ir_a, 3'b111);
    chk({tag, ".a.busy"}, busy_a, 1'b0);
    chk({tag, ".a.out_data"}, od_a, 24'd0);
    chk({tag, ".b.out_valid"}, ov_b, 3'b000);
    chk({tag, ".b.occ"}, occ_b, 9'd0);
    chk({tag, ".b.in_ready"}, ir_b, 3'b111);
    chk({tag, ".b.busy"}, busy_b, 1'b0);
    chk({tag, ".b.out_data"}, od_b, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] bseq [4];
    iv_a = '0; or_a = '0; id_a = '0; flush_a = 1'b0;
    iv_b = '0; or_b = '0; id_b = '0; flush_b = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b1, 1'b1, 8'h11};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 2, 1'b0, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b1, 1'b1, 8'h22};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b1, 1'b1, 8'h33};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1, 1'b1, 1'b1, 8'h44};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h55, 0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h66, 1, 1'b1, 1'b1, 8'h66};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00};

    // Reset state is visible before any clock edge
    rst = 1'b1;
    #1;
    check_reset_outputs("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_a();

    // Table-driven vectors on channel 0 of instance A
    for (int i = 0; i < 11; i++) begin
      step_a({2'b00, tbl[i].iv}, {2'b00, tbl[i].ordy}, tbl[i].fl, {16'h0, tbl[i].d});
      chk($sformatf("tbl%0d.occ", i), occ_a[1:0], tbl[i].e_occ);
      chk($sformatf("tbl%0d.in_ready", i), ir_a[0], tbl[i].e_rdy);
      chk($sformatf("tbl%0d.out_valid", i), ov_a[0], tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d.head", i), od_a[7:0], tbl[i].e_head);
    end

    // Reset mid-stream: two entries in ch0, then rst with no clock edge
    step_a(3'b001, 3'b000, 1'b0, 24'h0000A1);
    step_a(3'b001, 3'b000, 1'b0, 24'h0000A2);
    chk("rstmid.pre_occ", occ_a[1:0], 2'd2);
    iv_a = '0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    for (int k = 0; k < 3; k++) qa[k].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_a();

    // Full backpressure at depth 2, third item accepted only after ready rises
    step_a(3'b001, 3'b000, 1'b0, 24'h00000A);
    step_a(3'b001, 3'b000, 1'b0, 24'h00000B);
    chk("bp.full_ready", ir_a[0], 1'b0);
    step_a(3'b001, 3'b001, 1'b0, 24'h00000C);
    chk("bp.ready_rose", ir_a[0], 1'b1);
    chk("bp.occ_after_pop", occ_a[1:0], 2'd1);
    chk("bp.head_after_pop", od_a[7:0], 8'h0B);
    step_a(3'b001, 3'b000, 1'b0, 24'h00000C);
    chk("bp.occ_third", occ_a[1:0], 2'd2);
    step_a(3'b000, 3'b001, 1'b0, 24'h0);
    chk("bp.head_third", od_a[7:0], 8'h0C);
    step_a(3'b000, 3'b001, 1'b0, 24'h0);

    // Sustained push+pop at occupancy 1
    step_a(3'b001, 3'b000, 1'b0, 24'h000040);
    for (int i = 0; i < 20; i++) begin
      step_a(3'b001, 3'b001, 1'b0, {16'h0, 8'(8'h41 + i)});
      chk($sformatf("pp%0d.occ", i), occ_a[1:0], 2'd1);
      chk($sformatf("pp%0d.head", i), od_a[7:0], 8'(8'h41 + i));
    end
    step_a(3'b000, 3'b001, 1'b0, 24'h0);

    // Flush with push and pop on every channel in the same cycle
    step_a(3'b111, 3'b000, 1'b0, 24'h332211);
    step_a(3'b111, 3'b000, 1'b0, 24'h665544);
    step_a(3'b111, 3'b111, 1'b1, 24'h998877);
    chk("flush.occ", occ_a, 6'd0);
    chk("flush.busy", busy_a, 1'b0);
    chk("flush.out_valid", ov_a, 3'b000);
    step_a(3'b000, 3'b000, 1'b0, 24'h0);

    // Channel independence: ch2 stalled full while ch0 streams 100 items
    step_a(3'b100, 3'b000, 1'b0, 24'h770000);
    step_a(3'b100, 3'b000, 1'b0, 24'h880000);
    for (int i = 0; i < 100; i++) begin
      step_a(3'b101, 3'b001, 1'b0, {8'hEE, 8'h00, 8'(i)});
      chk($sformatf("ind%0d.ch0_ready", i), ir_a[0], 1'b1);
    end
    chk("ind.ch2_occ", occ_a[5:4], 2'd2);
    chk("ind.ch2_head", od_a[23:16], 8'h77);
    step_a(3'b000, 3'b101, 1'b0, 24'h0);
    chk("ind.ch2_second", od_a[23:16], 8'h88);
    step_a(3'b000, 3'b100, 1'b0, 24'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [23:0] rd;
      logic [2:0]  riv, ror;
      rd  = 24'($urandom);
      riv = 3'($urandom);
      ror = 3'($urandom);
      step_a(riv, ror, ($urandom_range(0, 19) == 0), rd);
    end
    step_a(3'b000, 3'b000, 1'b1, 24'h0);

    // Instance B: latency and order on ch1
    step_b(3'b010, 3'b010, 3'b010);
    chk("lat.valid", ov_b[1], 1'b1);
    chk("lat.d0", od_b[1], 1'b1);
    chk("lat.occ0", occ_b[5:3], 3'd1);
    step_b(3'b010, 3'b010, 3'b000);
    chk("lat.d1", od_b[1], 1'b0);
    chk("lat.occ1", occ_b[5:3], 3'd1);
    step_b(3'b010, 3'b010, 3'b010);
    chk("lat.d2", od_b[1], 1'b1);
    step_b(3'b000, 3'b010, 3'b000);
    chk("lat.empty", ov_b[1], 1'b0);
    chk("lat.busy", busy_b, 1'b0);

    // Instance B: fill ch0 to depth 4, overflow push ignored, drain in order
    bseq[0] = 2'b01; bseq[1] = 2'b00; bseq[2] = 2'b00; bseq[3] = 2'b01;
    for (int i = 0; i < 4; i++) step_b(3'b001, 3'b000, {2'b00, bseq[i][0]});
    chk("b.full_occ", occ_b[2:0], 3'd4);
    chk("b.full_ready", ir_b[0], 1'b0);
    step_b(3'b001, 3'b000, 3'b000);
    chk("b.overflow_occ", occ_b[2:0], 3'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b.drain%0d", i), od_b[0], bseq[i][0]);
      step_b(3'b000, 3'b001, 3'b000);
    end
    chk("b.drained", ov_b[0], 1'b0);
    chk("b.drained_occ", occ_b[2:0], 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_slice_bank.md
PORT_SLICE_BANK -- requirements
Module: port_slice_bank

Interface
REQ-001 Parameter NCH, default 3: number of independent channels, legal range 1..16.
REQ-002 Parameter WIDTH, default 1: data bits per channel, legal range 1..64.
REQ-003 Parameter DEPTH, default 2: entries per channel buffer, legal values 2 or 4.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all channel buffers.
REQ-007 in_valid  input  NCH  per-channel write request.
REQ-008 in_ready  output  NCH  per-channel write acceptance.
REQ-009 in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  NCH  per-channel data available.
REQ-011 out_ready  input  NCH  per-channel read acceptance.
REQ-012 out_data  output  NCH*WIDTH  channel k head entry, same packing as in_data.
REQ-013 occ  output  NCH*$clog2(DEPTH+1)  per-channel occupancy count, same packing rule.
REQ-014 busy  output  1  OR of all out_valid bits.

Function
REQ-015 Each channel shall be an independent DEPTH-entry FIFO, with no coupling between channels other than flush and rst.
REQ-016 A push shall occur on a rising edge where in_valid[k] && in_ready[k] && !flush.
REQ-017 A pop shall occur on a rising edge where out_valid[k] && out_ready[k] && !flush.
REQ-018 in_ready[k] shall be driven directly from a flop and equal (occ[k] < DEPTH), with no combinational path from out_ready.
REQ-019 out_valid[k] shall equal (occ[k] != 0), driven from a flop.
REQ-020 out_data[k] shall present the oldest entry from a register with no combinational path from in_data; when out_valid[k]=0 its value is don't-care and shall not be checked.
REQ-021 Latency: data pushed into an empty channel shall appear on out_data with out_valid=1 on the next cycle.
REQ-022 A simultaneous push and pop shall leave occ unchanged and preserve FIFO order, including when occ=1.
REQ-023 Full boundary: at occ=DEPTH, in_ready=0; a pop in that cycle shall raise in_ready on the following cycle only, so the same-cycle push is not accepted.
REQ-024 Empty boundary: at occ=0, out_ready shall have no effect.
REQ-025 Read and write pointers shall wrap modulo DEPTH, and occ shall never exceed DEPTH or underflow.
REQ-026 flush=1 shall set every occ to 0 at the edge, discarding all entries; same-cycle pushes and pops shall be ignored.
REQ-027 in_valid asserted while in_ready=0 shall be ignored with no state change; the upstream side holds data.

Reset
REQ-028 While rst=1, outputs shall immediately be out_valid=0, occ=0, in_ready=all ones, busy=0, and out_data=0.
REQ-029 Deassertion of rst shall be synchronous to clk by the integrator; the first push may occur on the first edge after deassertion.
REQ-030 Reset asserted mid-transfer shall discard all entries; no partial state shall survive.
REQ-031 Storage arrays other than head data may be left unreset.

Structure
REQ-032 A shared package port_slice_pkg shall hold the default constants NCH_DEF, WIDTH_DEF and DEPTH_DEF, and an occupancy-width function.
REQ-033 Per-channel logic shall be a sub-module slice_fifo, replicated NCH times by generate.
REQ-034 The top level shall only pack and unpack signals and form busy.

Verification
REQ-035 Reset mid-stream: fill ch0 with 2 entries, assert rst -> out_valid=0, occ=0 and in_ready=3'b111 immediately, without waiting for a clock edge.
REQ-036 Latency/order: push 1,0,1 on ch1 (WIDTH=1, DEPTH=4) with out_ready=1 -> out_valid rises 1 cycle after the first push and outputs 1,0,1 in order.
REQ-037 Full backpressure: DEPTH=2, out_ready=0, push A and B -> in_ready=0; then pop with in_valid held -> the third item is accepted exactly 1 cycle after in_ready rises.
REQ-038 Simultaneous push/pop at occ=1 for 20 cycles -> occ stays 1 and no data is lost or duplicated.
REQ-039 Flush with push and pop in the same cycle on all channels -> next cycle occ=0 on every channel and busy=0.
REQ-040 Channel independence: ch2 stalled full while ch0 streams 100 items -> ch0 has no stalls and ch2 contents are unchanged.
